// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and load/store, assembling little-endian words.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests (default: fixed MEM-over-IF priority).
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_ack_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_ack_o,
  output logic [31:0]       mem_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_own_mem;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_n;
  logic [2:0]          r_cyc;
  logic [31:0]         r_wdata;
  logic [31:0]         r_asm;
  logic [31:0]         r_inst;
  logic [31:0]         r_rdata;

  logic                w_if_ok;
  logic                w_grant_mem;
  logic                w_grant_if;
  logic [2:0]          w_len_n;
  logic [2:0]          w_n_acc;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic                w_acc_we;
  logic                w_flush_if;
  logic                w_unused;

  assign w_unused = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  assign w_if_ok = if_req_i && !flush_i;

`ifdef MEM_ARB_RR_EN
  logic r_last_mem;
  // On a tie, the requester that did not win last time is granted.
  assign w_grant_mem = mem_req_i && (!w_if_ok || !r_last_mem);
`else
  assign w_grant_mem = mem_req_i;
`endif
  assign w_grant_if = w_if_ok && !w_grant_mem;

  always_comb begin
    w_len_n = 3'd4;
    case (mem_len_i)
      2'b00:   w_len_n = 3'd1;
      2'b01:   w_len_n = 3'd2;
      default: w_len_n = 3'd4;
    endcase
  end

  assign w_n_acc    = w_grant_mem ? w_len_n : 3'd4;
  assign w_acc_addr = w_grant_mem ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
  assign w_acc_we   = w_grant_mem && mem_we_i;
  assign w_flush_if = flush_i && !r_own_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Reads need one extra cycle after the last address for the final byte to return.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_mem)     w_next = mem_we_i ? S_WR : S_RD;
        else if (w_grant_if) w_next = S_RD;
      end
      S_RD: begin
        if (w_flush_if)                 w_next = S_IDLE;
        else if (r_cyc == r_n + 3'd1)   w_next = S_ACK;
      end
      S_WR: begin
        if (r_cyc == r_n) w_next = S_ACK;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_own_mem  <= 1'b0;
      r_addr     <= '0;
      r_n        <= '0;
      r_cyc      <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_inst     <= '0;
      r_rdata    <= '0;
      ram_addr_o <= '0;
      ram_dout_o <= '0;
      ram_wr_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem || w_grant_if) begin
            r_own_mem  <= w_grant_mem;
            r_addr     <= w_acc_addr;
            r_n        <= w_n_acc;
            r_cyc      <= 3'd1;
            r_wdata    <= mem_wdata_i;
            r_asm      <= '0;
            ram_addr_o <= w_acc_addr;
            ram_wr_o   <= w_acc_we;
            if (w_acc_we) ram_dout_o <= mem_wdata_i[7:0];
          end
        end
        S_RD: begin
          r_cyc <= r_cyc + 3'd1;
          if (r_cyc < r_n) ram_addr_o <= r_addr + ADDR_W'(r_cyc);
          if (r_cyc >= 3'd2) r_asm[{r_cyc[1:0] - 2'd2, 3'b000} +: 8] <= ram_din_i;
        end
        S_WR: begin
          r_cyc <= r_cyc + 3'd1;
          if (r_cyc < r_n) begin
            ram_addr_o <= r_addr + ADDR_W'(r_cyc);
            ram_dout_o <= r_wdata[{r_cyc[1:0], 3'b000} +: 8];
          end else begin
            ram_wr_o <= 1'b0;
          end
        end
        default: begin
          if (if_ack_o)  r_inst  <= r_asm;
          if (mem_ack_o) r_rdata <= r_asm;
        end
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                 r_last_mem <= 1'b0;
    else if (r_state == S_IDLE && (w_grant_mem || w_grant_if)) r_last_mem <= w_grant_mem;
  end
`endif

  // A flush landing in the IF ack cycle suppresses the ack and keeps the old instruction.
  assign if_ack_o    = (r_state == S_ACK) && !r_own_mem && !flush_i;
  assign mem_ack_o   = (r_state == S_ACK) && r_own_mem;
  assign if_inst_o   = if_ack_o  ? r_asm : r_inst;
  assign mem_rdata_o = mem_ack_o ? r_asm : r_rdata;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model that returns read data one cycle after the address.
module tb_mem_arbiter;

  localparam int ADDR_W = 17;

  logic              clk;
  logic              rst;
  logic              flush_i;
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_ack_o;
  logic [31:0]       if_inst_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_ack_o;
  logic [31:0]       mem_rdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;
  logic [7:0]        ram_din_i;
  logic              busy_o;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  int n_tot;
  int n_bad;
  int if_c, mem_c, end_c, if_n, mem_n, wr_ack;
  logic [31:0] inst_seen, rdata_seen;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_inst_o(if_inst_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_din_i <= ram[ram_addr_o];
    if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Starts at cycle 0 (just after an edge, DUT idle); the next edge is the accept edge.
  task automatic run(input bit ie, input logic [31:0] ia, input bit me, input bit we,
                     input logic [1:0] len, input logic [31:0] ma, input logic [31:0] wd,
                     input int fl);
    if_c = 0; mem_c = 0; end_c = 0; if_n = 0; mem_n = 0; wr_ack = 0;
    inst_seen = '0; rdata_seen = '0;
    if_req_i = ie; if_addr_i = ia;
    mem_req_i = me; mem_we_i = we; mem_len_i = len; mem_addr_i = ma; mem_wdata_i = wd;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      flush_i = (k == fl);
      if (k == fl) if_req_i = 1'b0;
      if (if_ack_o) begin
        if_n++;
        if (if_c == 0) begin if_c = k; inst_seen = if_inst_o; end
        if_req_i = 1'b0;
      end
      if (mem_ack_o) begin
        mem_n++;
        if (ram_wr_o) wr_ack++;
        if (mem_c == 0) begin mem_c = k; rdata_seen = mem_rdata_o; end
        mem_req_i = 1'b0;
      end
      if (!busy_o && !if_req_i && !mem_req_i) begin
        end_c = k;
        break;
      end
    end
    flush_i = 1'b0;
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
  endtask

  initial begin
    n_tot = 0; n_bad = 0;
    rst = 1'b0; flush_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = '0; mem_wdata_i = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'h00;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    ram[32'h104] = 8'h93; ram[32'h105] = 8'h05; ram[32'h106] = 8'h20; ram[32'h107] = 8'h00;
    ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'h44;
    ram[32'h40] = 8'h8F;
    ram[32'h51] = 8'h34; ram[32'h52] = 8'hF2;
    ram[32'h300] = 8'hAA; ram[32'h301] = 8'hBB; ram[32'h302] = 8'hCC; ram[32'h303] = 8'hDD;
    ram[32'h1FFFE] = 8'h01; ram[32'h1FFFF] = 8'h02; ram[32'h0] = 8'h03; ram[32'h1] = 8'h04;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_wr", {31'd0, ram_wr_o}, 32'd0);
    chk("rst_acks", {30'd0, if_ack_o, mem_ack_o}, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    chk("rst_addr", 32'(ram_addr_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0);
    chk("fetch_cyc", if_c, 6);
    chk("fetch_data", inst_seen, 32'h00100513);
    chk("fetch_one_ack", if_n, 1);
    chk("fetch_end", end_c, 7);
    chk("fetch_hold", if_inst_o, 32'h00100513);

    run(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h2001, 32'hAABBCCDD, 0);
    chk("sth_cyc", mem_c, 3);
    chk("sth_wr_in_ack", wr_ack, 0);
    chk("sth_b0", {24'd0, ram[32'h2000]}, 32'h11);
    chk("sth_b1", {24'd0, ram[32'h2001]}, 32'hDD);
    chk("sth_b2", {24'd0, ram[32'h2002]}, 32'hCC);
    chk("sth_b3", {24'd0, ram[32'h2003]}, 32'h44);

    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 0);
    chk("ldb_cyc", mem_c, 3);
    chk("ldb_data", rdata_seen, 32'h0000008F);

    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h51, 32'h0, 0);
    chk("ldh_cyc", mem_c, 4);
    chk("ldh_data", rdata_seen, 32'h0000F234);
    chk("ldh_hold", mem_rdata_o, 32'h0000F234);

    run(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h500, 32'hCAFEF00D, 0);
    chk("stw_cyc", mem_c, 5);
    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 0);
    chk("ldw_len3_cyc", mem_c, 6);
    chk("ldw_back", rdata_seen, 32'hCAFEF00D);

    run(1'b1, 32'h100, 1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 0);
`ifdef MEM_ARB_RR_EN
    chk("tie_if_cyc", if_c, 6);
    chk("tie_mem_cyc", mem_c, 13);
`else
    chk("tie_mem_cyc", mem_c, 6);
    chk("tie_if_cyc", if_c, 13);
`endif
    chk("tie_mem_data", rdata_seen, 32'hDDCCBBAA);
    chk("tie_if_data", inst_seen, 32'h00100513);

    run(1'b1, 32'h104, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3);
    chk("flush_no_ack", if_n, 0);
    chk("flush_idle_cyc", end_c, 4);
    chk("flush_inst_kept", if_inst_o, 32'h00100513);
    run(1'b1, 32'h104, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0);
    chk("refetch_cyc", if_c, 6);
    chk("refetch_data", inst_seen, 32'h00200593);

    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h0001FFFE, 32'h0, 0);
    chk("wrap_data", rdata_seen, 32'h04030201);
    run(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'hFFF00040, 32'h0, 0);
    chk("hi_addr_data", rdata_seen, 32'h0000008F);

    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
    mem_addr_i = 32'h3000; mem_wdata_i = 32'h55667788;
    @(posedge clk); #1;
    chk("rst_store_started", {31'd0, ram_wr_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_wr", {31'd0, ram_wr_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_ack", {31'd0, mem_ack_o}, 32'd0);
    mem_req_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_b0", {24'd0, ram[32'h3000]}, 32'h88);
    chk("rst_mid_b1", {24'd0, ram[32'h3001]}, 32'h00);
    chk("rst_mid_b2", {24'd0, ram[32'h3002]}, 32'h00);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
